// File: rtl/mode1_port_handshake_if.sv
// Purpose : Bundle of the CPU-side and peripheral-side signals of one strobed
//           (Mode 1) PPI port. The handshake engine connects via the slave
//           modport. The CPU/peripheral side (or a testbench) uses the master
//           modport.
// Signals : mode_input  1 = strobed input, 0 = strobed output
//           inte        interrupt enable
//           cpu_rd      one-cycle CPU read pulse
//           cpu_wr      one-cycle CPU write pulse
//           cpu_wdata   data from data bus buffer
//           cpu_rdata   data returned to the CPU
//           port_in     port pins, input direction
//           port_out    port pins, output direction
//           port_oe     1 = drive port_out onto the pins
//           stb_n       asynchronous peripheral strobe, active low
//           ack_n       asynchronous peripheral acknowledge, active low
//           ibf         input buffer full
//           obf_n       output buffer full, active low
//           intr        interrupt request
//           overrun     sticky flag: data overwritten before it was consumed
interface mode1_port_handshake_if #(
  parameter int WIDTH = 8
);
  logic             mode_input;
  logic             inte;
  logic             cpu_rd;
  logic             cpu_wr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic [WIDTH-1:0] port_in;
  logic [WIDTH-1:0] port_out;
  logic             port_oe;
  logic             stb_n;
  logic             ack_n;
  logic             ibf;
  logic             obf_n;
  logic             intr;
  logic             overrun;

  modport master (
    output mode_input, inte, cpu_rd, cpu_wr, cpu_wdata, port_in, stb_n, ack_n,
    input  cpu_rdata, port_out, port_oe, ibf, obf_n, intr, overrun
  );

  modport slave (
    input  mode_input, inte, cpu_rd, cpu_wr, cpu_wdata, port_in, stb_n, ack_n,
    output cpu_rdata, port_out, port_oe, ibf, obf_n, intr, overrun
  );
endinterface

// File: rtl/mode1_port_handshake.sv
// Purpose : Strobed (Mode 1) handshake engine for one PPI port.
//           Input mode latches the port pins on a falling STB_n and raises
//           IBF, then INTR on the rising STB_n.
//           Output mode holds CPU-written data and runs the OBF_n/ACK_n
//           exchange with the peripheral.
//           The peripheral strobes are asynchronous. They are resynchronised
//           here before edge detection.
// Ports   : clk      system clock, rising edge
//           reset_n  synchronous active-low reset
//           bus      mode1_port_handshake_if.slave (see interface header)
// Params  : WIDTH        port data width
//           SYNC_STAGES  synchroniser depth on stb_n/ack_n (>= 2)
module mode1_port_handshake #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mode1_port_handshake_if.slave bus
);

  // One buffer, either empty or full. Which flag it drives depends on the
  // mode it was filled in.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   stb_s, ack_s;
  logic                   stb_prev, ack_prev;
  logic                   stb_fall, stb_rise, ack_fall, ack_rise;

  logic                   mode_prev;
  logic                   mode_change;
  logic                   full;

  logic [WIDTH-1:0]       in_reg, in_reg_nxt;
  logic [WIDTH-1:0]       out_reg, out_reg_nxt;
  logic                   intr_q, intr_q_nxt;
  logic                   overrun_q, overrun_nxt;

  // Synchronisers and edge-detect history.
  // They reset to 1 so that an idle (high) strobe produces no edge after
  // reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stb_sync <= '1;
      ack_sync <= '1;
      stb_prev <= 1'b1;
      ack_prev <= 1'b1;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], bus.stb_n};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_n};
      stb_prev <= stb_s;
      ack_prev <= ack_s;
    end
  end

  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign stb_fall = stb_prev & ~stb_s;
  assign stb_rise = ~stb_prev & stb_s;
  assign ack_fall = ack_prev & ~ack_s;
  assign ack_rise = ~ack_prev & ack_s;

  // mode_prev loads the live mode during reset.
  // This prevents the first cycle after reset from looking like a mode change.
  assign mode_change = (bus.mode_input != mode_prev);
  assign full        = (state == ST_FULL);

  // State and data registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_EMPTY;
      in_reg    <= '0;
      out_reg   <= '0;
      intr_q    <= 1'b0;
      overrun_q <= 1'b0;
      mode_prev <= bus.mode_input;
    end else begin
      state     <= state_nxt;
      in_reg    <= in_reg_nxt;
      out_reg   <= out_reg_nxt;
      intr_q    <= intr_q_nxt;
      overrun_q <= overrun_nxt;
      mode_prev <= bus.mode_input;
    end
  end

  // Next-state logic.
  // Within a mode, the CPU access is applied first and the strobe events
  // second, except that a CPU write in output mode is applied last.
  // This gives the required collision behaviour:
  //   - a read that coincides with a new strobe leaves the buffer full;
  //   - a write that coincides with an acknowledge leaves it full.
  // A read arriving with the strobe's rising edge consumes the data, so no
  // interrupt is raised for it.
  always_comb begin
    state_nxt   = state;
    in_reg_nxt  = in_reg;
    out_reg_nxt = out_reg;
    intr_q_nxt  = intr_q;
    overrun_nxt = overrun_q;

    if (mode_change) begin
      state_nxt   = ST_EMPTY;
      intr_q_nxt  = 1'b0;
      overrun_nxt = 1'b0;
    end else if (bus.mode_input) begin
      if (bus.cpu_rd) begin
        state_nxt   = ST_EMPTY;
        intr_q_nxt  = 1'b0;
        overrun_nxt = 1'b0;
      end else if (stb_rise && full) begin
        intr_q_nxt = 1'b1;
      end
      if (stb_fall) begin
        in_reg_nxt = bus.port_in;
        state_nxt  = ST_FULL;
        if (full && !bus.cpu_rd) begin
          overrun_nxt = 1'b1;
        end
      end
    end else begin
      if (bus.cpu_rd) begin
        overrun_nxt = 1'b0;
      end
      if (ack_fall) begin
        state_nxt = ST_EMPTY;
      end
      if (ack_rise && !full) begin
        intr_q_nxt = 1'b1;
      end
      if (bus.cpu_wr) begin
        out_reg_nxt = bus.cpu_wdata;
        state_nxt   = ST_FULL;
        intr_q_nxt  = 1'b0;
        if (full && !ack_fall) begin
          overrun_nxt = 1'b1;
        end
      end
    end
  end

  // Flags follow the registered mode.
  // Because of this, a mode flip clears them on the same edge that empties
  // the buffer.
  assign bus.ibf       = full & mode_prev;
  assign bus.obf_n     = ~(full & ~mode_prev);
  assign bus.intr      = intr_q & bus.inte;
  assign bus.overrun   = overrun_q;
  assign bus.cpu_rdata = bus.mode_input ? in_reg : out_reg;
  assign bus.port_out  = out_reg;
  assign bus.port_oe   = reset_n & ~bus.mode_input;

endmodule

// File: tb/tb_mode1_port_handshake.sv
// Purpose : Self-checking bench for mode1_port_handshake.
//           A directed sequence covers reset, input, overrun, output,
//           collision and abort. A randomized run follows.
//           Every cycle is compared against a behavioural model of the port.
module tb_mode1_port_handshake;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int HIST  = SYNC + 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mode1_port_handshake_if #(.WIDTH(WIDTH)) bus ();

  mode1_port_handshake #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int num_compared   = 0;
  int num_mismatched = 0;

  // Reference model.
  // Pin history is a delay line: an edge takes effect SYNC+1 clocks after it
  // hits the pin.
  logic [WIDTH-1:0] m_in, m_out;
  bit               m_ibf, m_obf_full, m_intr, m_ovr, m_mode_prev;
  bit               stb_h[HIST];
  bit               ack_h[HIST];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelEdge();
    bit sf, sr, af, ar, rd, wr, was_full;
    if (!reset_n) begin
      m_in = '0; m_out = '0;
      m_ibf = 0; m_obf_full = 0; m_intr = 0; m_ovr = 0;
      m_mode_prev = bus.mode_input;
      for (int i = 0; i < HIST; i++) begin
        stb_h[i] = 1'b1;
        ack_h[i] = 1'b1;
      end
    end else begin
      for (int i = HIST - 1; i > 0; i--) begin
        stb_h[i] = stb_h[i-1];
        ack_h[i] = ack_h[i-1];
      end
      stb_h[0] = bus.stb_n;
      ack_h[0] = bus.ack_n;
      sf = !stb_h[SYNC] && stb_h[SYNC+1];
      sr = stb_h[SYNC] && !stb_h[SYNC+1];
      af = !ack_h[SYNC] && ack_h[SYNC+1];
      ar = ack_h[SYNC] && !ack_h[SYNC+1];
      rd = bus.cpu_rd;
      wr = bus.cpu_wr;
      if (bus.mode_input != m_mode_prev) begin
        m_ibf = 0; m_obf_full = 0; m_intr = 0; m_ovr = 0;
      end else if (bus.mode_input) begin
        was_full = m_ibf;
        if (sf) m_in = bus.port_in;
        m_ibf  = sf ? 1'b1 : (rd ? 1'b0 : was_full);
        m_intr = rd ? 1'b0 : ((sr && was_full) ? 1'b1 : m_intr);
        m_ovr  = (sf && was_full && !rd) ? 1'b1 : (rd ? 1'b0 : m_ovr);
      end else begin
        was_full = m_obf_full;
        if (rd) m_ovr = 0;
        if (wr) begin
          m_out = bus.cpu_wdata;
          m_obf_full = 1;
          m_intr = 0;
          if (was_full && !af) m_ovr = 1;
        end else begin
          if (af) m_obf_full = 0;
          if (ar && !was_full) m_intr = 1;
        end
      end
      m_mode_prev = bus.mode_input;
    end
  endtask

  // One clock with the currently driven inputs, followed by a full
  // comparison against the model.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("ibf",       32'(bus.ibf),       32'(m_ibf));
    checkOutput("obf_n",     32'(bus.obf_n),     32'(!m_obf_full));
    checkOutput("intr",      32'(bus.intr),      32'(m_intr && bus.inte));
    checkOutput("overrun",   32'(bus.overrun),   32'(m_ovr));
    checkOutput("cpu_rdata", 32'(bus.cpu_rdata), 32'(bus.mode_input ? m_in : m_out));
    checkOutput("port_out",  32'(bus.port_out),  32'(m_out));
    checkOutput("port_oe",   32'(bus.port_oe),   32'(reset_n && !bus.mode_input));
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus();
  endtask

  initial begin
    bit flip, rise_stb, rise_ack;

    reset_n        = 1'b0;
    bus.mode_input = 1'b1;
    bus.inte       = 1'b1;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_wdata  = '0;
    bus.port_in    = 8'hA5;
    bus.stb_n      = 1'b1;
    bus.ack_n      = 1'b1;

    // Reset
    runCycles(2);
    checkOutput("rst_ibf",   32'(bus.ibf),     32'd0);
    checkOutput("rst_obf_n", 32'(bus.obf_n),   32'd1);
    checkOutput("rst_intr",  32'(bus.intr),    32'd0);
    checkOutput("rst_ovr",   32'(bus.overrun), 32'd0);
    checkOutput("rst_oe",    32'(bus.port_oe), 32'd0);
    reset_n = 1'b1;
    runCycles(2);

    // Input strobe
    bus.stb_n = 1'b0;
    runCycles(2);
    checkOutput("in_ibf_early", 32'(bus.ibf), 32'd0);
    applyStimulus();
    checkOutput("in_ibf_3clk", 32'(bus.ibf), 32'd1);
    applyStimulus();
    bus.stb_n = 1'b1;
    runCycles(2);
    checkOutput("in_intr_early", 32'(bus.intr), 32'd0);
    applyStimulus();
    checkOutput("in_intr_3clk", 32'(bus.intr), 32'd1);
    bus.cpu_rd = 1'b1;
    checkOutput("in_rdata", 32'(bus.cpu_rdata), 32'h A5);
    applyStimulus();
    bus.cpu_rd = 1'b0;
    checkOutput("in_rd_ibf",  32'(bus.ibf),  32'd0);
    checkOutput("in_rd_intr", 32'(bus.intr), 32'd0);

    // Input overrun
    bus.port_in = 8'h11;
    bus.stb_n = 1'b0; runCycles(2);
    bus.stb_n = 1'b1; runCycles(5);
    bus.port_in = 8'h22;
    bus.stb_n = 1'b0; runCycles(2);
    bus.stb_n = 1'b1; runCycles(5);
    checkOutput("ovr_rdata", 32'(bus.cpu_rdata), 32'h22);
    checkOutput("ovr_flag",  32'(bus.overrun),   32'd1);
    bus.inte = 1'b0;
    applyStimulus();
    checkOutput("ovr_masked", 32'(bus.intr), 32'd0);
    bus.inte = 1'b1;
    applyStimulus();
    checkOutput("ovr_unmasked", 32'(bus.intr), 32'd1);
    bus.cpu_rd = 1'b1; applyStimulus(); bus.cpu_rd = 1'b0;
    checkOutput("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Output handshake
    bus.mode_input = 1'b0;
    applyStimulus();
    checkOutput("out_oe", 32'(bus.port_oe), 32'd1);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h3C;
    applyStimulus();
    bus.cpu_wr = 1'b0;
    checkOutput("out_data",  32'(bus.port_out), 32'h3C);
    checkOutput("out_obf_n", 32'(bus.obf_n),    32'd0);
    bus.ack_n = 1'b0;
    runCycles(2);
    checkOutput("out_obf_early", 32'(bus.obf_n), 32'd0);
    applyStimulus();
    checkOutput("out_obf_3clk", 32'(bus.obf_n), 32'd1);
    applyStimulus();
    bus.ack_n = 1'b1;
    runCycles(2);
    checkOutput("out_intr_early", 32'(bus.intr), 32'd0);
    applyStimulus();
    checkOutput("out_intr_3clk", 32'(bus.intr), 32'd1);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'h5A;
    applyStimulus();
    bus.cpu_wr = 1'b0;
    checkOutput("out_wr_intr", 32'(bus.intr), 32'd0);

    // Collision: write on the ack_fall detection edge
    bus.ack_n = 1'b0;
    runCycles(2);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'hC3;
    applyStimulus();
    bus.cpu_wr = 1'b0;
    checkOutput("col_obf_n", 32'(bus.obf_n),    32'd0);
    checkOutput("col_ovr",   32'(bus.overrun),  32'd0);
    checkOutput("col_data",  32'(bus.port_out), 32'hC3);
    bus.ack_n = 1'b1;
    runCycles(5);

    // Mode flip with obf_n low
    bus.mode_input = 1'b1;
    applyStimulus();
    checkOutput("flip_obf_n", 32'(bus.obf_n),    32'd1);
    checkOutput("flip_keep",  32'(bus.port_out), 32'hC3);

    // Abort mid-handshake
    bus.port_in = 8'h5E;
    bus.stb_n = 1'b0; runCycles(2);
    bus.stb_n = 1'b1; runCycles(5);
    checkOutput("abort_pre_ibf",  32'(bus.ibf),  32'd1);
    checkOutput("abort_pre_intr", 32'(bus.intr), 32'd1);
    reset_n = 1'b0;
    applyStimulus();
    checkOutput("abort_ibf",  32'(bus.ibf),     32'd0);
    checkOutput("abort_intr", 32'(bus.intr),    32'd0);
    checkOutput("abort_ovr",  32'(bus.overrun), 32'd0);
    reset_n = 1'b1;
    runCycles(2);

    // Randomized run.
    // CPU accesses are kept off mode-flip cycles and off cycles where a
    // rising strobe lands, so each event's outcome is unambiguous.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset_n = ($urandom_range(0, 249) != 0);
      flip = ($urandom_range(0, 79) == 0);
      if (flip) bus.mode_input = ~bus.mode_input;
      if ($urandom_range(0, 19) == 0) bus.inte = ~bus.inte;
      if ($urandom_range(0, 5) == 0) bus.stb_n = ~bus.stb_n;
      if ($urandom_range(0, 5) == 0) bus.ack_n = ~bus.ack_n;
      bus.port_in   = WIDTH'($urandom);
      bus.cpu_wdata = WIDTH'($urandom);
      rise_stb = stb_h[SYNC-1] && !stb_h[SYNC];
      rise_ack = ack_h[SYNC-1] && !ack_h[SYNC];
      bus.cpu_rd = !flip && ($urandom_range(0, 7) == 0);
      bus.cpu_wr = !flip && !bus.cpu_rd && ($urandom_range(0, 7) == 0);
      if (bus.mode_input && rise_stb) bus.cpu_rd = 1'b0;
      if (!bus.mode_input && rise_ack) bus.cpu_wr = 1'b0;
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
